// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared definitions for the instruction fetch unit. It holds
//                the fetch state enumeration and a small state-decode helper.
//                The package has no ports.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // The encoding is fixed so that waveforms and any external decode agree.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_e;

    // True while the unit is working through the address range.
    function automatic logic is_active(input fetch_state_e s);
        return (s == ST_FETCH) || (s == ST_DRAIN);
    endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_if
//  Description : Bus bundle between the fetch unit, its combinational
//                instruction memory, the branch source and the consumer.
//                Signals:
//                  mem_addr  / mem_data  : memory address out, read data in
//                  br_valid  / br_target : redirect request and its address
//                  out_valid / out_ready : output word handshake
//                  instr     / instr_pc  : fetched word and its address
//                The master modport is the fetch unit side; the slave
//                modport is the environment side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 2
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              br_valid;
    logic [ADDR_W-1:0] br_target;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output mem_addr,
        input  mem_data,
        input  br_valid,
        input  br_target,
        output out_valid,
        input  out_ready,
        output instr,
        output instr_pc
    );

    modport slave (
        input  mem_addr,
        output mem_data,
        output br_valid,
        output br_target,
        input  out_valid,
        output out_ready,
        input  instr,
        input  instr_pc
    );
endinterface : fetch_if
`default_nettype wire

// File: rtl/fetch_pc.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc
//  Description : Program counter with load, increment and end-of-range
//                handling. With WRAP=1 the counter rolls over to 0. With
//                WRAP=0 it sticks at the last address.
//                Ports:
//                  clk, rst   : clock and synchronous active-high reset
//                  i_load     : load i_load_val (has priority over i_inc)
//                  i_load_val : value to load
//                  i_inc      : advance to the next address
//                  o_pc       : current program counter
//                  o_last     : pc is at the final address and will not wrap
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc #(
    parameter int ADDR_W = 2,
    parameter bit WRAP   = 1'b0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_load,
    input  wire logic [ADDR_W-1:0] i_load_val,
    input  wire logic              i_inc,
    output logic      [ADDR_W-1:0] o_pc,
    output logic                   o_last
);
    localparam logic [ADDR_W-1:0] C_PC_MAX = '1;
    localparam logic [ADDR_W-1:0] C_PC_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;

    assign o_last = (r_pc == C_PC_MAX) && !WRAP;

    always_comb begin
        w_pc_nxt = r_pc;
        if (i_load) begin
            w_pc_nxt = i_load_val;
        end else if (i_inc && !o_last) begin
            // Modulo-2^ADDR_W add. It only reaches 0 when WRAP=1.
            w_pc_nxt = r_pc + C_PC_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc_nxt;
        end
    end

    assign o_pc = r_pc;

endmodule : fetch_pc
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Sequential instruction fetcher. After a start pulse it reads
//                a combinational memory from address 0 and presents one word
//                per cycle through a valid/ready output register. It honours
//                consumer backpressure and branch redirects.
//                Ports:
//                  clk, rst : clock and synchronous active-high reset
//                  start    : begin fetching at address 0 (from IDLE/DONE)
//                  bus      : fetch_if master (memory, branch, output word)
//                  busy     : high in FETCH or DRAIN
//                  done     : high in DONE
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 2,
    parameter bit WRAP   = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic start,
    fetch_if.master   bus,
    output logic      busy,
    output logic      done
);
    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic              r_out_valid;
    logic              w_out_valid_nxt;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] w_instr_nxt;
    logic [ADDR_W-1:0] r_instr_pc;
    logic [ADDR_W-1:0] w_instr_pc_nxt;

    logic              w_pc_load;
    logic [ADDR_W-1:0] w_pc_load_val;
    logic              w_pc_inc;
    logic [ADDR_W-1:0] w_pc;
    logic              w_pc_last;
    logic              w_handshake;

    fetch_pc #(
        .ADDR_W (ADDR_W),
        .WRAP   (WRAP)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_pc_load),
        .i_load_val (w_pc_load_val),
        .i_inc      (w_pc_inc),
        .o_pc       (w_pc),
        .o_last     (w_pc_last)
    );

    assign w_handshake = r_out_valid && bus.out_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_out_valid_nxt = r_out_valid;
        w_instr_nxt     = r_instr;
        w_instr_pc_nxt  = r_instr_pc;
        w_pc_load       = 1'b0;
        w_pc_load_val   = '0;
        w_pc_inc        = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt     = ST_FETCH;
                    w_out_valid_nxt = 1'b0;
                    w_pc_load       = 1'b1;
                end
            end
            ST_FETCH: begin
                if (bus.br_valid) begin
                    // A redirect drops any held word. If it handshakes in
                    // this same cycle, it has already been consumed.
                    w_out_valid_nxt = 1'b0;
                    w_pc_load       = 1'b1;
                    w_pc_load_val   = bus.br_target;
                end else if (!r_out_valid || bus.out_ready) begin
                    w_instr_nxt     = bus.mem_data;
                    w_instr_pc_nxt  = w_pc;
                    w_out_valid_nxt = 1'b1;
                    w_pc_inc        = 1'b1;
                    if (w_pc_last) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.br_valid) begin
                    w_state_nxt     = ST_FETCH;
                    w_out_valid_nxt = 1'b0;
                    w_pc_load       = 1'b1;
                    w_pc_load_val   = bus.br_target;
                end else if (w_handshake) begin
                    w_state_nxt     = ST_DONE;
                    w_out_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_instr     <= '0;
            r_instr_pc  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_instr     <= w_instr_nxt;
            r_instr_pc  <= w_instr_pc_nxt;
        end
    end

    assign bus.mem_addr  = w_pc;
    assign bus.out_valid = r_out_valid;
    assign bus.instr     = r_instr;
    assign bus.instr_pc  = r_instr_pc;
    assign busy          = is_active(r_state);
    assign done          = (r_state == ST_DONE);

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. It drives a stop-at-end
//                instance and a wrapping instance from a 4-word memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic clk;
    logic rst0, start0, busy0, done0;
    logic rst1, start1, busy1, done1;

    fetch_if #(.ADDR_W(2), .DATA_W(2)) b0 ();
    fetch_if #(.ADDR_W(2), .DATA_W(2)) b1 ();

    logic [1:0] mem_rom [0:3] = '{2'b00, 2'b01, 2'b00, 2'b10};

    assign b0.mem_data = mem_rom[b0.mem_addr];
    assign b1.mem_data = mem_rom[b1.mem_addr];

    fetch_unit #(.ADDR_W(2), .DATA_W(2), .WRAP(1'b0)) dut0 (
        .clk   (clk),
        .rst   (rst0),
        .start (start0),
        .bus   (b0),
        .busy  (busy0),
        .done  (done0)
    );

    fetch_unit #(.ADDR_W(2), .DATA_W(2), .WRAP(1'b1)) dut1 (
        .clk   (clk),
        .rst   (rst1),
        .start (start1),
        .bus   (b1),
        .busy  (busy1),
        .done  (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       start;
        logic       br_v;
        logic [1:0] br_t;
        logic       rdy;
        logic       ov;
        logic       chk_w;
        logic [1:0] ipc;
        logic [1:0] ins;
        logic [1:0] maddr;
        logic       busy;
        logic       done;
    } vec_t;

    typedef struct {
        logic [1:0] pc;
        logic [1:0] data;
    } word_t;

    vec_t  vq[$];
    word_t q0[$];
    word_t q1[$];
    int    n_vec  = 0;
    int    n_miss = 0;
    int    pops1  = 0;

    function automatic vec_t mk(input logic rst, input logic start, input logic br_v,
                                input logic [1:0] br_t, input logic rdy, input logic ov,
                                input logic chk_w, input logic [1:0] ipc, input logic [1:0] ins,
                                input logic [1:0] maddr, input logic busy, input logic done);
        vec_t v;
        v.rst = rst; v.start = start; v.br_v = br_v; v.br_t = br_t; v.rdy = rdy;
        v.ov = ov; v.chk_w = chk_w; v.ipc = ipc; v.ins = ins; v.maddr = maddr;
        v.busy = busy; v.done = done;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_miss++;
            $display("FAIL %s [%0d]: got %0h, want %0h", name, idx, act, exp_v);
        end
    endtask

    task automatic push_word(input int which, input logic [1:0] pc);
        word_t w;
        w.pc   = pc;
        w.data = mem_rom[pc];
        if (which == 0) q0.push_back(w);
        else            q1.push_back(w);
    endtask

    // Words transfer at the coming edge when valid & ready, unless reset wins.
    task automatic sb_check();
        word_t e;
        if (!rst0 && b0.out_valid && b0.out_ready) begin
            if (q0.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL sb0_unexpected: got pc %0d, want no transfer", b0.instr_pc);
            end else begin
                e = q0.pop_front();
                chk("sb0_pc", n_vec, {6'd0, b0.instr_pc}, {6'd0, e.pc});
                chk("sb0_instr", n_vec, {6'd0, b0.instr}, {6'd0, e.data});
            end
        end
        if (!rst1 && b1.out_valid && b1.out_ready) begin
            if (q1.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL sb1_unexpected: got pc %0d, want no transfer", b1.instr_pc);
            end else begin
                e = q1.pop_front();
                pops1++;
                chk("sb1_pc", n_vec, {6'd0, b1.instr_pc}, {6'd0, e.pc});
                chk("sb1_instr", n_vec, {6'd0, b1.instr}, {6'd0, e.data});
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sb_check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_pcs0[6] = '{0, 1, 2, 3, 0, 3};
        int exp_pcs1[6] = '{0, 1, 2, 3, 0, 1};
        vec_t v;

        rst0 = 1'b1; start0 = 1'b0; rst1 = 1'b1; start1 = 1'b0;
        b0.br_valid = 1'b0; b0.br_target = 2'd0; b0.out_ready = 1'b0;
        b1.br_valid = 1'b0; b1.br_target = 2'd0; b1.out_ready = 1'b0;

        //          rst st  br  bt    rdy ov  cw  ipc   ins    maddr busy done
        vq.push_back(mk(1, 0, 0, 2'd0, 0, 0, 1, 2'd0, 2'b00, 2'd0, 0, 0)); // reset state
        vq.push_back(mk(0, 1, 0, 2'd0, 1, 0, 0, 2'd0, 2'b00, 2'd0, 1, 0)); // start
        vq.push_back(mk(0, 0, 0, 2'd0, 1, 1, 1, 2'd0, 2'b00, 2'd1, 1, 0)); // word 0, 1-cycle latency
        vq.push_back(mk(0, 0, 0, 2'd0, 1, 1, 1, 2'd1, 2'b01, 2'd2, 1, 0));
        vq.push_back(mk(0, 0, 0, 2'd0, 1, 1, 1, 2'd2, 2'b00, 2'd3, 1, 0));
        vq.push_back(mk(0, 0, 0, 2'd0, 1, 1, 1, 2'd3, 2'b10, 2'd3, 1, 0)); // last word, DRAIN
        vq.push_back(mk(0, 0, 0, 2'd0, 1, 0, 0, 2'd0, 2'b00, 2'd3, 0, 1)); // DONE
        vq.push_back(mk(0, 1, 0, 2'd0, 0, 0, 0, 2'd0, 2'b00, 2'd0, 1, 0)); // restart from DONE
        vq.push_back(mk(0, 0, 0, 2'd0, 0, 1, 1, 2'd0, 2'b00, 2'd1, 1, 0)); // first word
        vq.push_back(mk(0, 0, 0, 2'd0, 0, 1, 1, 2'd0, 2'b00, 2'd1, 1, 0)); // backpressure x3
        vq.push_back(mk(0, 0, 0, 2'd0, 0, 1, 1, 2'd0, 2'b00, 2'd1, 1, 0));
        vq.push_back(mk(0, 0, 0, 2'd0, 0, 1, 1, 2'd0, 2'b00, 2'd1, 1, 0));
        vq.push_back(mk(0, 0, 0, 2'd0, 1, 1, 1, 2'd1, 2'b01, 2'd2, 1, 0)); // released
        vq.push_back(mk(0, 0, 1, 2'd3, 0, 0, 0, 2'd0, 2'b00, 2'd3, 1, 0)); // branch drops (1,01)
        vq.push_back(mk(0, 0, 0, 2'd0, 0, 1, 1, 2'd3, 2'b10, 2'd3, 1, 0)); // fetched at target
        vq.push_back(mk(0, 0, 0, 2'd0, 1, 0, 0, 2'd0, 2'b00, 2'd3, 0, 1)); // drained -> DONE
        vq.push_back(mk(0, 0, 1, 2'd2, 0, 0, 0, 2'd0, 2'b00, 2'd3, 0, 1)); // branch in DONE ignored
        vq.push_back(mk(0, 1, 0, 2'd0, 0, 0, 0, 2'd0, 2'b00, 2'd0, 1, 0)); // restart
        vq.push_back(mk(0, 1, 0, 2'd0, 0, 1, 1, 2'd0, 2'b00, 2'd1, 1, 0)); // start in FETCH ignored
        vq.push_back(mk(0, 1, 0, 2'd0, 0, 1, 1, 2'd0, 2'b00, 2'd1, 1, 0));
        vq.push_back(mk(1, 1, 1, 2'd2, 1, 0, 1, 2'd0, 2'b00, 2'd0, 0, 0)); // reset mid-operation
        vq.push_back(mk(0, 0, 0, 2'd0, 0, 0, 1, 2'd0, 2'b00, 2'd0, 0, 0)); // idle after reset

        for (int i = 0; i < 6; i++) push_word(0, exp_pcs0[i][1:0]);

        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            rst0         = v.rst;
            start0       = v.start;
            b0.br_valid  = v.br_v;
            b0.br_target = v.br_t;
            b0.out_ready = v.rdy;
            tick();
            chk("out_valid", i, {7'd0, b0.out_valid}, {7'd0, v.ov});
            chk("mem_addr", i, {6'd0, b0.mem_addr}, {6'd0, v.maddr});
            chk("busy", i, {7'd0, busy0}, {7'd0, v.busy});
            chk("done", i, {7'd0, done0}, {7'd0, v.done});
            if (v.chk_w) begin
                chk("instr_pc", i, {6'd0, b0.instr_pc}, {6'd0, v.ipc});
                chk("instr", i, {6'd0, b0.instr}, {6'd0, v.ins});
            end
        end
        chk("sb0_left", 0, 8'(q0.size()), 8'd0);

        // Wrapping instance: six back-to-back words roll over past address 3.
        rst0 = 1'b1; start0 = 1'b0; b0.out_ready = 1'b0; b0.br_valid = 1'b0;
        rst1 = 1'b0; start1 = 1'b1; b1.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) push_word(1, exp_pcs1[i][1:0]);
        tick();
        start1 = 1'b0;
        for (int c = 0; c < 20 && pops1 < 6; c++) begin
            tick();
            chk("wrap_done", c, {7'd0, done1}, 8'd0);
        end
        b1.out_ready = 1'b0;
        chk("wrap_pops", 0, 8'(pops1), 8'd6);
        chk("wrap_busy", 0, {7'd0, busy1}, 8'd1);
        chk("wrap_ipc", 0, {6'd0, b1.instr_pc}, 8'd2);
        chk("wrap_maddr", 0, {6'd0, b1.mem_addr}, 8'd3);

        // Reset while a word is held under backpressure.
        tick();
        chk("held_ov", 0, {7'd0, b1.out_valid}, 8'd1);
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        chk("rst_ov", 0, {7'd0, b1.out_valid}, 8'd0);
        chk("rst_maddr", 0, {6'd0, b1.mem_addr}, 8'd0);
        chk("rst_busy", 0, {7'd0, busy1}, 8'd0);
        chk("sb1_left", 0, 8'(q1.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 2, SHALL set the memory address and program-counter width.
REQ-002 Parameter DATA_W, default 2, SHALL set the memory data and instruction width.
REQ-003 Parameter WRAP, default 0, SHALL select stop-at-end (0) or wrap to address 0 (1).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 start  input  1  SHALL be a pulse that begins fetching at address 0 from IDLE or DONE.
REQ-007 mem_addr  output  ADDR_W  SHALL be the address driven to the combinational memory.
REQ-008 mem_data  input  DATA_W  SHALL be the memory word read combinationally at mem_addr in the same cycle.
REQ-009 br_valid  input  1  SHALL request a redirect of the fetch address.
REQ-010 br_target  input  ADDR_W  SHALL be the redirect address, sampled when br_valid=1.
REQ-011 out_valid  output  1  SHALL indicate instr/instr_pc hold a fetched word.
REQ-012 out_ready  input  1  SHALL indicate the consumer accepts the word this cycle.
REQ-013 instr  output  DATA_W  SHALL be the registered fetched word.
REQ-014 instr_pc  output  ADDR_W  SHALL be the address instr was read from.
REQ-015 busy  output  1  SHALL be 1 in FETCH or DRAIN.
REQ-016 done  output  1  SHALL be 1 in DONE.

Function
REQ-017 States SHALL be IDLE, FETCH, DRAIN, DONE; mem_addr SHALL equal pc in every state.
REQ-018 IDLE/DONE with start=1 SHALL go to FETCH with pc=0, out_valid=0; start in FETCH/DRAIN SHALL be ignored.
REQ-019 Capture condition: state FETCH, br_valid=0, and (out_valid=0 or out_ready=1).
REQ-020 On capture: instr<=mem_data, instr_pc<=pc, out_valid<=1, pc<=pc+1 modulo 2^ADDR_W.
REQ-021 Handshake: word transfers when out_valid&out_ready; with no capture that cycle out_valid SHALL fall to 0.
REQ-022 Backpressure: out_valid=1 and out_ready=0 SHALL hold instr, instr_pc, pc, mem_addr unchanged.
REQ-023 Latency: start sampled at edge k SHALL give out_valid=1 with instr_pc=0 after edge k+1; sustained throughput one word per cycle with out_ready=1.
REQ-024 Branch in FETCH or DRAIN: pc<=br_target, out_valid<=0 (held word discarded unless handshaked that same cycle, which counts as transferred), state<=FETCH; branch has priority over capture.
REQ-025 End of range, WRAP=0: capture at pc=2^ADDR_W-1 SHALL go to DRAIN, pc unchanged; DRAIN SHALL go to DONE on handshake, out_valid falling to 0.
REQ-026 End of range, WRAP=1: pc SHALL wrap to 0 and state stay FETCH; DRAIN/DONE never entered except by branch rules.
REQ-027 br_valid in IDLE or DONE SHALL be ignored.

Reset
REQ-028 rst=1 at an edge SHALL force state IDLE, pc=0, mem_addr=0, out_valid=0, instr=0, instr_pc=0, busy=0, done=0, overriding start, br_valid and handshake, including mid-operation.

Structure
REQ-029 The state enumeration and its encoding SHALL live in a shared package fetch_pkg.
REQ-030 The pc register with load, increment and wrap/stop logic SHALL be a sub-module fetch_pc; state machine and output register stay in fetch_unit.

Verification (ADDR_W=2, DATA_W=2, bench memory: addr0->00, 1->01, 2->00, 3->10)
REQ-031 rst, start at edge k, out_ready=1 -> (instr_pc,instr)=(0,00),(1,01),(2,00),(3,10) after edges k+1..k+4, then done=1, out_valid=0.
REQ-032 out_ready=0 for 3 cycles after first word -> instr_pc=0, instr=00, mem_addr=1 held; out_ready=1 -> next word (1,01).
REQ-033 br_valid=1, br_target=3 while word (1,01) held with out_ready=0 -> next cycle out_valid=0, mem_addr=3; following cycle (3,10).
REQ-034 WRAP=1, out_ready=1 for 6 words -> instr_pc sequence 0,1,2,3,0,1; done stays 0.
REQ-035 rst during FETCH with out_valid=1 -> after the edge state IDLE, out_valid=0, mem_addr=0; start pulse in FETCH -> pc unaffected.
